// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed driver for a common-anode multi-digit 7-segment display.
//   One digit is lit per scan slot. Each slot starts with a short all-dark
//   window to stop ghosting. Display data is double-buffered:
//   - load writes the pending set.
//   - The pending set is copied to the active set only at the frame boundary.
//   Because of this, a frame never mixes old and new digits.
//
// Parameters
//   NUM_DIGITS  number of digits scanned (1..8)
//   SCAN_DIV    clock cycles per digit slot (>= BLANK_CYC+2)
//   BLANK_CYC   dark cycles at the start of every slot
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   load        one-cycle strobe capturing value_in / blank_in / dp_in
//   value_in    hex nibbles, digit 0 = bits [3:0] (rightmost)
//   blank_in    1 = digit forced dark
//   dp_in       1 = decimal point lit on that digit
//   digit_n     anode enables, active-low, at most one low
//   seg_n       segments {a,b,c,d,e,f,g} = [6:0], active-low
//   dp_n        decimal point, active-low
//   frame_done  one-cycle pulse after each complete scan
//
// Optional feature
//   LEADING_ZERO_BLANK_EN : when defined, digit k (k >= 1) is also blanked
//   while it and all higher nibbles are zero. A lit decimal point at or
//   above the digit stops this suppression. Digit 0 is never suppressed.
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   digit_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRESC_W = $clog2(SCAN_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYC);

    // Hex nibble to active-low segment pattern {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        case (nib)
            4'h0:    seg_enc = 7'h01;
            4'h1:    seg_enc = 7'h4F;
            4'h2:    seg_enc = 7'h12;
            4'h3:    seg_enc = 7'h06;
            4'h4:    seg_enc = 7'h4C;
            4'h5:    seg_enc = 7'h24;
            4'h6:    seg_enc = 7'h20;
            4'h7:    seg_enc = 7'h0F;
            4'h8:    seg_enc = 7'h00;
            4'h9:    seg_enc = 7'h04;
            4'hA:    seg_enc = 7'h08;
            4'hB:    seg_enc = 7'h60;
            4'hC:    seg_enc = 7'h31;
            4'hD:    seg_enc = 7'h42;
            4'hE:    seg_enc = 7'h30;
            4'hF:    seg_enc = 7'h38;
            default: seg_enc = 7'h7F;
        endcase
    endfunction

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_q, frame_d;
    logic                    boundary_s;
    logic [3:0]              nib_s;
    logic                    dark_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;

    assign boundary_s = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

    // Slot prescaler and digit index counters
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = {PRESC_W{1'b0}};
            if (idx_q == IDX_LAST) begin
                idx_d = {IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Double buffer: a load on the boundary cycle bypasses straight to active
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        act_val_d    = act_val_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        if (load) begin
            pend_val_d   = value_in;
            pend_blank_d = blank_in;
            pend_dp_d    = dp_in;
        end else begin
            pend_val_d   = pend_val_q;
        end
        if (boundary_s) begin
            act_val_d   = pend_val_d;
            act_blank_d = pend_blank_d;
            act_dp_d    = pend_dp_d;
        end else begin
            act_val_d   = act_val_q;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; suppression holds while nibbles stay zero
    // and no decimal point has been seen at or above the current digit.
    always_comb begin : lz_calc
        logic run_v;
        run_v     = 1'b1;
        lz_mask_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run_v        = run_v && (act_val_q[4*k +: 4] == 4'h0) && !act_dp_q[k];
            lz_mask_s[k] = run_v;
        end
    end
`else
    assign lz_mask_s = {NUM_DIGITS{1'b0}};
`endif

    // Decode of the current slot into next output values
    always_comb begin
        nib_s   = act_val_q[{idx_q, 2'b00} +: 4];
        dark_s  = (presc_q < BLANK_END) || act_blank_q[idx_q] || lz_mask_s[idx_q];
        frame_d = boundary_s;
        digit_d = {NUM_DIGITS{1'b1}};
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (dark_s) begin
            digit_d = {NUM_DIGITS{1'b1}};
        end else begin
            digit_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = seg_enc(nib_s);
            dp_d    = ~act_dp_q[idx_q];
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= {PRESC_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            pend_val_q   <= {(4*NUM_DIGITS){1'b0}};
            pend_blank_q <= {NUM_DIGITS{1'b1}};
            pend_dp_q    <= {NUM_DIGITS{1'b0}};
            act_val_q    <= {(4*NUM_DIGITS){1'b0}};
            act_blank_q  <= {NUM_DIGITS{1'b1}};
            act_dp_q     <= {NUM_DIGITS{1'b0}};
            digit_q      <= {NUM_DIGITS{1'b1}};
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_q      <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            act_val_q    <= act_val_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            digit_q      <= digit_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign digit_n    = digit_q;
    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=8 and
//   BLANK_CYC=2. Each frame is checked cycle by cycle against hand-written
//   per-slot segment patterns.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;
    logic [3:0]  blank_in = 4'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  digit_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seg7_scan_driver #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_in   (value_in),
        .blank_in   (blank_in),
        .dp_in      (dp_in),
        .digit_n    (digit_n),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Wait (bounded) for frame_done with no data loaded; display must stay dark
    task automatic wait_frame();
        int  cnt = 0;
        bit  seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(negedge clk);
            cnt++;
            if (frame_done) begin
                seen = 1'b1;
            end else begin
                check_eq("idle_digit", 32'(digit_n), 32'h0000000F);
                check_eq("idle_seg", 32'(seg_n), 32'h0000007F);
            end
        end
        check_eq("frame_len", 32'(cnt), 32'd32);
    endtask

    // Check one full frame. Entry/exit: at the negedge where frame_done is high.
    // exp_seg packs slots {3,2,1,0}; two optional loads at cycles la / lb.
    task automatic check_frame(input logic [27:0] exp_seg, input logic [3:0] exp_dark,
                               input logic [3:0] exp_dpn,
                               input int la, input logic [23:0] lda,
                               input int lb, input logic [23:0] ldb);
        for (int i = 0; i < 32; i++) begin
            int         s;
            int         p;
            logic [3:0] e_dig;
            logic [6:0] e_seg;
            logic       e_dp;
            load = 1'b0;
            if (i == la) begin
                load = 1'b1;
                {value_in, blank_in, dp_in} = lda;
            end else if (i == lb) begin
                load = 1'b1;
                {value_in, blank_in, dp_in} = ldb;
            end
            @(negedge clk);
            s = i / 8;
            p = i % 8;
            if (p < 2 || exp_dark[s]) begin
                e_dig = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                e_dig = ~(4'b0001 << s);
                e_seg = exp_seg[7*s +: 7];
                e_dp  = exp_dpn[s];
            end
            check_eq("digit_n", 32'(digit_n), 32'(e_dig));
            check_eq("seg_n", 32'(seg_n), 32'(e_seg));
            check_eq("dp_n", 32'(dp_n), 32'(e_dp));
            check_eq("frame_done", 32'(frame_done), (i == 31) ? 32'd1 : 32'd0);
        end
        load = 1'b0;
    endtask

    initial begin
        logic [3:0] dark5;
        logic [3:0] dark6;
        logic [3:0] dark7;
`ifdef LEADING_ZERO_BLANK_EN
        dark5 = 4'b1110;
        dark6 = 4'b1110;
        dark7 = 4'b1000;
`else
        dark5 = 4'b0000;
        dark6 = 4'b0000;
        dark7 = 4'b0000;
`endif
        // Reset hold
        repeat (3) @(negedge clk);
        check_eq("rst_digit", 32'(digit_n), 32'h0000000F);
        check_eq("rst_seg", 32'(seg_n), 32'h0000007F);
        check_eq("rst_dp", 32'(dp_n), 32'd1);
        check_eq("rst_frame", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        wait_frame();

        // Dark frame; 1234 loaded into pending
        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF, 0, {16'h1234, 4'h0, 4'h0}, -1, 24'h0);
        // 1234 shown; mid-frame load of 8888 must not tear
        check_frame({7'h4F, 7'h12, 7'h06, 7'h4C}, 4'h0, 4'hF, 12, {16'h8888, 4'h0, 4'h0}, -1, 24'h0);
        // 8888 shown; two loads, the last one wins
        check_frame({7'h00, 7'h00, 7'h00, 7'h00}, 4'h0, 4'hF, 5, {16'hFFFF, 4'h0, 4'hF},
                    20, {16'hE0E0, 4'b0100, 4'b0001});
        // E0E0 with slot2 blanked, dp on slot0; load on the boundary cycle
        check_frame({7'h30, 7'h7F, 7'h30, 7'h01}, 4'b0100, 4'b1110, 31, {16'h0005, 4'h0, 4'h0}, -1, 24'h0);
        // 0005 (bypassed straight to active)
        check_frame({7'h01, 7'h01, 7'h01, 7'h24}, dark5, 4'hF, 3, {16'h0000, 4'h0, 4'h0}, -1, 24'h0);
        // 0000
        check_frame({7'h01, 7'h01, 7'h01, 7'h01}, dark6, 4'hF, 3, {16'h0000, 4'h0, 4'b0100}, -1, 24'h0);
        // 0000 with dp on digit 2
        check_frame({7'h01, 7'h01, 7'h01, 7'h01}, dark7, 4'b1011, -1, 24'h0, -1, 24'h0);

        // Into slot 2, lit, then asynchronous reset
        repeat (20) @(negedge clk);
        check_eq("pre_rst_digit", 32'(digit_n), 32'h0000000B);
        check_eq("pre_rst_seg", 32'(seg_n), 32'h00000001);
        rst_n = 1'b0;
        #1;
        check_eq("arst_digit", 32'(digit_n), 32'h0000000F);
        check_eq("arst_seg", 32'(seg_n), 32'h0000007F);
        check_eq("arst_dp", 32'(dp_n), 32'd1);
        check_eq("arst_frame", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame();

        check_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'hF, 4'hF, 0, {16'hBA98, 4'h0, 4'h0}, -1, 24'h0);
        check_frame({7'h60, 7'h08, 7'h04, 7'h00}, 4'h0, 4'hF, 10, {16'h7C6D, 4'h0, 4'b1000}, -1, 24'h0);
        check_frame({7'h0F, 7'h31, 7'h20, 7'h42}, 4'h0, 4'b0111, -1, 24'h0, -1, 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display, built on the game's hex-to-segment encoding. It scans NUM_DIGITS digits, one per slot, and decodes each 4-bit nibble to active-low segments with per-digit blanking and decimal point. Input data is double-buffered so the value never changes mid-frame. It sits between the reaction-time counter/score logic and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4: number of digits scanned (1..8).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ BLANK_CYC+2).
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off (anti-ghosting).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle strobe capturing value_in, blank_in, dp_in.
- value_in  in  4*NUM_DIGITS  hex nibbles; digit 0 = bits [3:0] (rightmost).
- blank_in  in  NUM_DIGITS  1 = digit forced dark.
- dp_in  in  NUM_DIGITS  1 = decimal point lit on that digit.
- digit_n  out  NUM_DIGITS  anode enables, active-low, at most one low.
- seg_n  out  7  segments {a,b,c,d,e,f,g} = [6:0], active-low.
- dp_n  out  1  decimal point, active-low.
- frame_done  out  1  one-cycle pulse at end of each full scan.

## Operation
- Encoding (seg_n, hex): 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F 8=00 9=04 A=08 b=60 C=31 d=42 E=30 F=38.
- Registers: pending set {val, blank, dp} written on load; active set used for display.
- Counters: presc 0..SCAN_DIV-1; idx 0..NUM_DIGITS-1, advances when presc wraps; idx wraps NUM_DIGITS-1→0.
- Frame boundary: presc==SCAN_DIV-1 and idx==NUM_DIGITS-1. At this edge pending→active and frame_done is set for one cycle.
- load on the boundary cycle: new inputs go to both pending and active (the new data wins).
- load more than once per frame: the last one wins. No tearing: digits of one frame always come from one active set.
- Slot output: if presc < BLANK_CYC, or active blank[idx] is set, then digit_n is all 1s, seg_n=7F and dp_n=1. Otherwise digit_n[idx]=0, seg_n=enc(nibble idx), dp_n=~dp[idx].
- Reset state: presc=0, idx=0, pending/active val=0, blank=all 1s, dp=0. The display stays dark until the first load reaches active.

## Timing
- All outputs registered. Output in cycle t+1 reflects counter/active state in cycle t (1-cycle latency).
- Reset values: digit_n all 1s, seg_n=7'h7F, dp_n=1, frame_done=0.
- Frame length = NUM_DIGITS*SCAN_DIV cycles. Lit time per slot = SCAN_DIV-BLANK_CYC cycles.
- load → visible: appears in the first lit slot after the next frame boundary. Worst case ≈ NUM_DIGITS*SCAN_DIV+BLANK_CYC+1 cycles.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). After release, scan restarts at idx 0, presc 0.
- NUM_DIGITS=1: idx constant 0; every slot end is a frame boundary.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit k is additionally blanked when its nibble and all higher nibbles in the active set are 0, for k ≥ 1.
  - Digit 0 is never suppressed.
  - A lit dp on a digit stops suppression at and below that digit.
- LEADING_ZERO_BLANK_EN undefined: zeros are displayed; only blank_in blanks.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset hold then release → digit_n=4'hF, seg_n=7'h7F, dp_n=1, frame_done=0; stays dark for a full frame with no load.
- load value_in=16'h1234, blank_in=0, dp_in=0 → from next frame: slot0 digit_n=4'hE seg_n=4C; slot1 4'hD/06; slot2 4'hB/12; slot3 4'h7/4F. First 2 cycles of each slot dark; frame_done every 32 cycles.
- Mid-frame load 16'h8888 after 16'h1234 is displayed → remainder of current frame still shows 1234; next frame all digits seg_n=00.
- blank_in=4'b0100, dp_in=4'b0001, value 16'hE0E0 → slot2 dark. Slot0 seg_n=01 with dp_n=0. Slot1 seg_n=30 and slot3 seg_n=30, each with dp_n=1.
- LEADING_ZERO_BLANK_EN, value 16'h0005 → slots 3..1 dark, slot0 seg_n=24. Value 16'h0000 → only slot0 lit, seg_n=01.
- rst_n low for 1 cycle in slot 2 → outputs at reset values immediately. After release: dark until a new load plus one frame boundary; idx restarts at 0.
